// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes over a 128-bit state using LANES S-box lanes per beat.
// States: IDLE accepts a block | RUN substitutes LANES bytes per beat | DONE holds the result until taken.
module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0][31:0] state_i,
  input  logic             enc_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0][31:0] state_o,
  output logic             busy
);

  localparam int NBEATS = 16 / LANES;
  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    res_q, res_d;
  logic            mode_q, mode_d;
  logic            rdy_q;
  logic [LANES*8-1:0] lane_in, lane_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  // Both directions share one field inversion per lane
  function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic enc);
    logic [7:0] t;
    logic [7:0] g;
    t = enc ? x : inv_affine(x);
    g = gf_inv(t);
    return enc ? affine(g) : g;
  endfunction

  always_comb begin
    lane_in  = '0;
    lane_out = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_in[8*j +: 8]  = data_q[8*(int'(beat_q)*LANES + j) +: 8];
      lane_out[8*j +: 8] = sbox_lane(lane_in[8*j +: 8], mode_q);
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    mode_d  = mode_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && rdy_q) begin
          data_d  = state_i;
          mode_d  = enc_dec;
          beat_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int j = 0; j < LANES; j++)
          res_d[8*(int'(beat_q)*LANES + j) +: 8] = lane_out[8*j +: 8];
        if (beat_q == LAST_BEAT) state_d = S_DONE;
        else beat_d = beat_q + CW'(1);
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      rdy_q   <= 1'b1;
    end
  end

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign state_o   = res_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: directed and randomized blocks against a table-driven S-box model,
// with one instance per legal LANES value sharing the same stimulus.
module tb_sub_bytes_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, enc_dec, out_ready;
  logic [3:0][31:0] state_i;
  logic             ir [5];
  logic             ov [5];
  logic             bz [5];
  logic [3:0][31:0] so [5];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .state_i(state_i), .enc_dec(enc_dec), .out_valid(ov[g]),
      .out_ready(out_ready), .state_o(so[g]), .busy(bz[g])
    );
  end

  logic [127:0] rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] fwd   [256];
  logic [7:0] inv_t [256];

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic enc);
    logic [127:0] r;
    for (int n = 0; n < 16; n++)
      r[8*n +: 8] = enc ? fwd[s[8*n +: 8]] : inv_t[s[8*n +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one block to the LANES=4 instance (assumed idle) and waits for its out_valid.
  // lat counts edges starting with the accepting one.
  task automatic run_block(input logic [127:0] data, input logic enc, input bit scramble,
                           output int lat);
    in_valid = 1'b1;
    state_i  = data;
    enc_dec  = enc;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (ov[2] !== 1'b1 && lat < 40) begin
      if (scramble) begin
        state_i  = rand128();
        enc_dec  = 1'($urandom);
        in_valid = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  logic [127:0] d, hold, exp_v;
  logic [127:0] res [5];
  int lats [5];
  int lat, cyc, stall;
  logic e;

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        fwd[16*r + c] = rows[r][127 - 8*c -: 8];
    for (int i = 0; i < 256; i++) inv_t[fwd[i]] = 8'(i);

    rst_n = 1'b0; in_valid = 1'b0; enc_dec = 1'b0; out_ready = 1'b0; state_i = '0;
    tick(); tick();
    check("rst_in_ready", 128'(ir[2]), 128'd0);
    check("rst_out_valid", 128'(ov[2]), 128'd0);
    check("rst_busy", 128'(bz[2]), 128'd0);
    check("rst_state_o", so[2], 128'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 128'(ir[2]), 128'd1);

    // all zeros forward
    out_ready = 1'b1;
    run_block(128'd0, 1'b1, 1'b0, lat);
    check("zero_fwd_latency", 128'(lat), 128'd5);
    check("zero_fwd_result", so[2], {16{8'h63}});
    check("zero_fwd_busy", 128'(bz[2]), 128'd1);
    tick();
    check("zero_fwd_idle_valid", 128'(ov[2]), 128'd0);
    check("zero_fwd_idle_ready", 128'(ir[2]), 128'd1);

    // inverse of 63, then counting bytes forward
    run_block({16{8'h63}}, 1'b0, 1'b0, lat);
    check("inv63_result", so[2], 128'd0);
    tick();
    for (int n = 0; n < 16; n++) d[8*n +: 8] = 8'(n);
    run_block(d, 1'b1, 1'b0, lat);
    check("count_word0", 128'(so[2][0]), 128'h7B777C63);
    check("count_word3", 128'(so[2][3]), 128'h76ABD7FE);
    check("count_full", so[2], ref_model(d, 1'b1));
    tick();

    // downstream stall in DONE
    out_ready = 1'b0;
    d = rand128();
    run_block(d, 1'b1, 1'b0, lat);
    hold = so[2];
    check("stall_result", hold, ref_model(d, 1'b1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      state_i  = rand128();
      enc_dec  = 1'($urandom);
      tick();
      check("stall_state_o", so[2], hold);
      check("stall_out_valid", 128'(ov[2]), 128'd1);
      check("stall_in_ready", 128'(ir[2]), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_out_valid", 128'(ov[2]), 128'd0);
    check("release_in_ready", 128'(ir[2]), 128'd1);
    tick();
    check("release_no_second", 128'(ov[2]), 128'd0);
    check("release_busy", 128'(bz[2]), 128'd0);

    // reset during beat 2
    in_valid = 1'b1; state_i = rand128(); enc_dec = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("midrun_busy", 128'(bz[2]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 128'(ov[2]), 128'd0);
    check("midrun_rst_state_o", so[2], 128'd0);
    check("midrun_rst_busy", 128'(bz[2]), 128'd0);
    check("midrun_rst_in_ready", 128'(ir[2]), 128'd0);
    #2 rst_n = 1'b1;
    tick();
    check("midrun_rel_in_ready", 128'(ir[2]), 128'd1);
    d = rand128();
    run_block(d, 1'b0, 1'b0, lat);
    check("after_rst_latency", 128'(lat), 128'd5);
    check("after_rst_result", so[2], ref_model(d, 1'b0));
    tick();

    // random back-to-back traffic with inputs scrambled during RUN
    for (int b = 0; b < 12; b++) begin
      d = rand128();
      e = 1'($urandom);
      out_ready = 1'b0;
      run_block(d, e, 1'b1, lat);
      check("rand_latency", 128'(lat), 128'd5);
      check("rand_result", so[2], ref_model(d, e));
      stall = int'($urandom_range(0, 2));
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rand_hold", so[2], ref_model(d, e));
      end
      out_ready = 1'b1;
      tick();
      check("rand_consumed", 128'(ov[2]), 128'd0);
    end

    // lane-count sweep, all instances start together from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    d = '0;
    d[7:0] = 8'h53;
    d[127:120] = 8'hFF;
    exp_v = {16{8'h63}};
    exp_v[7:0] = 8'hED;
    exp_v[127:120] = 8'h16;
    for (int g = 0; g < 5; g++) begin lats[g] = 0; res[g] = '0; end
    in_valid = 1'b1; state_i = d; enc_dec = 1'b1;
    tick();
    in_valid = 1'b0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      for (int g = 0; g < 5; g++)
        if (ov[g] === 1'b1 && lats[g] == 0) begin
          lats[g] = cyc;
          res[g]  = so[g];
        end
      tick();
    end
    for (int g = 0; g < 5; g++) begin
      check($sformatf("sweep_latency_lanes%0d", 1 << g), 128'(lats[g]), 128'(16 / (1 << g) + 1));
      check($sformatf("sweep_result_lanes%0d", 1 << g), res[g], exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
